// File: rtl/pixel_filter_pkg.sv
// Shared filter-mode encodings and luma weights for the pixel filter block.
package pixel_filter_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_GRAY   = 2'd1,
    MODE_INV    = 2'd2,
    MODE_THRESH = 2'd3
  } filter_mode_e;

  // Weights sum to 16 so the luma of a full-scale pixel is 240 >> 4 = 15.
  localparam logic [7:0] LUMA_W_R = 8'd5;
  localparam logic [7:0] LUMA_W_G = 8'd9;
  localparam logic [7:0] LUMA_W_B = 8'd2;

endpackage

// File: rtl/pixel_filter_rgb_luma.sv
// Combinational RGB444 to 4-bit luma, shared by the grayscale and threshold paths.
module rgb_luma
  import pixel_filter_pkg::*;
(
  input  logic [11:0] pixel,
  output logic [3:0]  luma
);

  logic [7:0] weighted_sum;

  assign weighted_sum = LUMA_W_R * {4'd0, pixel[11:8]}
                      + LUMA_W_G * {4'd0, pixel[7:4]}
                      + LUMA_W_B * {4'd0, pixel[3:0]};
  assign luma = weighted_sum[7:4];

endmodule

// File: rtl/pixel_filter.sv
// Streaming RGB444 pixel filter: reads the upstream FIFO, applies the selected
// filter and delivers pixels through a 2-entry skid buffer.
module pixel_filter
  import pixel_filter_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic [1:0]            i_mode,
  input  logic [3:0]            i_thresh,
  output logic                  o_rd,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_empty,
  output logic                  o_wr,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_full,
  output logic [15:0]           o_pix_count
);

  logic                  started;
  logic                  rd_pending;
  filter_mode_e          rd_mode;
  logic [3:0]            rd_thresh;
  logic                  cap_valid;
  logic [DATA_WIDTH-1:0] cap_data;
  filter_mode_e          cap_mode;
  logic [3:0]            cap_thresh;
  logic [3:0]            luma;
  logic [DATA_WIDTH-1:0] filt_data;
  logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;
  logic [15:0]           pix_count;
  logic                  push;
  logic                  pop;
  logic                  cap_free;
  logic [2:0]            credits_used;

  // The capture register stalls when the buffer is full, so it holds one extra
  // credit; that covers the 3-cycle read-to-pop loop at one pixel per cycle.
  assign pop          = (count != 2'd0) && !i_full;
  assign push         = cap_valid && ((count != 2'(BUF_DEPTH)) || pop);
  assign cap_free     = !cap_valid || push;
  assign credits_used = 3'(count) + 3'(rd_pending) + 3'(cap_valid) - 3'(pop);
  assign o_rd         = started && !i_empty && (credits_used < 3'(BUF_DEPTH + 1));
  assign o_wr         = pop;
  assign o_data       = buf_mem[rd_ptr];
  assign o_pix_count  = pix_count;

  rgb_luma u_luma (
    .pixel (cap_data),
    .luma  (luma)
  );

  always_comb begin
    filt_data = cap_data;
    case (cap_mode)
      MODE_GRAY:   filt_data = {luma, luma, luma};
      MODE_INV:    filt_data = ~cap_data;
      MODE_THRESH: filt_data = (luma >= cap_thresh) ? '1 : '0;
      default:     filt_data = cap_data;
    endcase
  end

  // Mode and threshold are tagged at the read so mid-stream changes only
  // affect pixels read afterwards.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      started    <= 1'b0;
      rd_pending <= 1'b0;
      rd_mode    <= MODE_PASS;
      rd_thresh  <= 4'd0;
      cap_valid  <= 1'b0;
      cap_data   <= '0;
      cap_mode   <= MODE_PASS;
      cap_thresh <= 4'd0;
    end else begin
      started    <= 1'b1;
      rd_pending <= o_rd;
      if (o_rd) begin
        rd_mode   <= filter_mode_e'(i_mode);
        rd_thresh <= i_thresh;
      end
      if (cap_free) begin
        cap_valid <= rd_pending;
        if (rd_pending) begin
          cap_data   <= i_data;
          cap_mode   <= rd_mode;
          cap_thresh <= rd_thresh;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < BUF_DEPTH; i++) buf_mem[i] <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      pix_count <= 16'd0;
    end else begin
      if (push) begin
        buf_mem[wr_ptr] <= filt_data;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr    <= ~rd_ptr;
        pix_count <= pix_count + 16'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_filter.sv
// Directed and randomized-flow bench for pixel_filter with a pixel scoreboard.
module tb_pixel_filter;

  logic        i_clk;
  logic        i_rstn;
  logic [1:0]  i_mode;
  logic [3:0]  i_thresh;
  logic        o_rd;
  logic [11:0] i_data;
  logic        i_empty;
  logic        o_wr;
  logic [11:0] o_data;
  logic        i_full;
  logic [15:0] o_pix_count;

  pixel_filter #(.DATA_WIDTH(12), .BUF_DEPTH(2)) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_mode      (i_mode),
    .i_thresh    (i_thresh),
    .o_rd        (o_rd),
    .i_data      (i_data),
    .i_empty     (i_empty),
    .o_wr        (o_wr),
    .o_data      (o_data),
    .i_full      (i_full),
    .o_pix_count (o_pix_count)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  typedef struct {
    logic [11:0] pix;
    logic [11:0] exp_pix;
    bit          has_exp;
  } src_t;

  src_t        src_q[$];
  logic [11:0] exp_q[$];
  int check_count = 0;
  int error_count = 0;
  int cyc = 0;
  int first_rd = -1;
  int first_wr = -1;
  int last_wr = -1;
  int full_hold = 0;
  int full_mode = 0;
  bit rand_empty = 0;
  bit rand_mode = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [11:0] pix, input logic [11:0] exp_pix, input bit has_exp);
    src_t s;
    s.pix = pix;
    s.exp_pix = exp_pix;
    s.has_exp = has_exp;
    src_q.push_back(s);
  endtask

  function automatic logic [11:0] model(input logic [11:0] p, input logic [1:0] m, input logic [3:0] t);
    int y;
    y = (5 * int'(p[11:8]) + 9 * int'(p[7:4]) + 2 * int'(p[3:0])) / 16;
    case (m)
      2'd0:    return p;
      2'd1:    return {y[3:0], y[3:0], y[3:0]};
      2'd2:    return ~p;
      default: return (y >= int'(t)) ? 12'hFFF : 12'h000;
    endcase
  endfunction

  // One clock cycle: drive flow-control inputs, sample outputs before the edge,
  // then deliver FIFO read data just after the edge.
  task automatic runCycle();
    logic rd, wr;
    logic [11:0] dat, next_data;
    src_t s;
    i_empty = (src_q.size() == 0) || (rand_empty && $urandom_range(0, 2) == 0);
    if (full_hold > 0) begin
      i_full = 1'b1;
      full_hold--;
    end else if (full_mode == 1) i_full = 1'b1;
    else if (full_mode == 2) i_full = ($urandom_range(0, 2) == 0);
    else i_full = 1'b0;
    if (rand_mode) begin
      i_mode = 2'($urandom_range(0, 3));
      i_thresh = 4'($urandom_range(0, 15));
    end
    #1;
    rd = o_rd;
    wr = o_wr;
    dat = o_data;
    next_data = 12'h000;
    if (i_empty) checkOutput("rd_while_empty", 32'(rd), 32'd0);
    if (i_full) checkOutput("wr_while_full", 32'(wr), 32'd0);
    if (wr) begin
      if (exp_q.size() == 0) checkOutput("unexpected_wr", 32'(dat), 32'hFFFFFFFF);
      else checkOutput("pixel", 32'(dat), 32'(exp_q.pop_front()));
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
    end
    if (rd && src_q.size() > 0) begin
      s = src_q.pop_front();
      exp_q.push_back(s.has_exp ? s.exp_pix : model(s.pix, i_mode, i_thresh));
      next_data = s.pix;
      if (first_rd < 0) first_rd = cyc;
    end
    @(posedge i_clk);
    #1;
    cyc++;
    i_data = rd ? next_data : 12'($urandom);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (src_q.size() > 0 || exp_q.size() > 0); i++) runCycle();
    checkOutput("drain_left", 32'(src_q.size() + exp_q.size()), 32'd0);
  endtask

  task automatic doReset();
    i_rstn = 1'b0;
    src_q.delete();
    exp_q.delete();
    repeat (2) @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
  endtask

  initial begin
    i_rstn = 1'b0;
    i_mode = 2'd0;
    i_thresh = 4'd0;
    i_data = 12'h000;
    i_empty = 1'b0;
    i_full = 1'b0;
    #3;
    checkOutput("reset_rd", 32'(o_rd), 32'd0);
    checkOutput("reset_wr", 32'(o_wr), 32'd0);
    checkOutput("reset_data", 32'(o_data), 32'd0);
    checkOutput("reset_count", 32'(o_pix_count), 32'd0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
    #1;
    checkOutput("rd_before_first_edge", 32'(o_rd), 32'd0);

    // Pass-through burst: latency and back-to-back delivery.
    for (int i = 0; i < 8; i++) applyStimulus(12'h123 + 12'(i), 12'h123 + 12'(i), 1'b1);
    drain(50);
    checkOutput("first_latency", 32'(first_wr - first_rd), 32'd3);
    checkOutput("burst_span", 32'(last_wr - first_wr), 32'd7);
    checkOutput("burst_count", 32'(o_pix_count), 32'd8);

    i_mode = 2'd1;
    applyStimulus(12'hF00, 12'h444, 1'b1);
    applyStimulus(12'h0F0, 12'h888, 1'b1);
    applyStimulus(12'h00F, 12'h111, 1'b1);
    applyStimulus(12'hFFF, 12'hFFF, 1'b1);
    drain(50);

    i_mode = 2'd2;
    applyStimulus(12'hA5C, 12'h5A3, 1'b1);
    drain(50);
    i_mode = 2'd3;
    i_thresh = 4'd7;
    applyStimulus(12'h777, 12'hFFF, 1'b1);
    drain(50);
    i_thresh = 4'd8;
    applyStimulus(12'h777, 12'h000, 1'b1);
    drain(50);

    // Mode switch between consecutive reads.
    i_mode = 2'd0;
    applyStimulus(12'h0F0, 12'h0F0, 1'b1);
    applyStimulus(12'h0F0, 12'h0F0, 1'b1);
    runCycle();
    runCycle();
    i_mode = 2'd2;
    applyStimulus(12'h0F0, 12'hF0F, 1'b1);
    applyStimulus(12'h0F0, 12'hF0F, 1'b1);
    drain(50);

    // Full pulse then random flow control and random modes.
    full_hold = 5;
    full_mode = 2;
    rand_empty = 1;
    rand_mode = 1;
    for (int i = 0; i < 1000; i++) applyStimulus(12'($urandom), 12'h000, 1'b0);
    drain(8000);
    full_mode = 0;
    rand_empty = 0;
    rand_mode = 0;
    i_mode = 2'd0;
    i_thresh = 4'd0;

    // Reset with two pixels parked in the skid buffer.
    full_mode = 1;
    applyStimulus(12'h5A5, 12'h5A5, 1'b1);
    applyStimulus(12'h3C3, 12'h3C3, 1'b1);
    repeat (6) runCycle();
    i_full = 1'b0;
    i_empty = 1'b0;
    i_rstn = 1'b0;
    #1;
    checkOutput("async_rst_wr", 32'(o_wr), 32'd0);
    checkOutput("async_rst_data", 32'(o_data), 32'd0);
    checkOutput("async_rst_rd", 32'(o_rd), 32'd0);
    checkOutput("async_rst_count", 32'(o_pix_count), 32'd0);
    src_q.delete();
    exp_q.delete();
    full_mode = 0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
    #1;
    checkOutput("rd_after_release", 32'(o_rd), 32'd0);
    applyStimulus(12'h0AB, 12'h0AB, 1'b1);
    applyStimulus(12'h0CD, 12'h0CD, 1'b1);
    applyStimulus(12'h0EF, 12'h0EF, 1'b1);
    drain(50);
    checkOutput("resume_count", 32'(o_pix_count), 32'd3);

    // Pixel counter wrap.
    doReset();
    for (int i = 0; i < 65534; i++) applyStimulus(12'(i), 12'(i), 1'b1);
    drain(66000);
    checkOutput("count_preload", 32'(o_pix_count), 32'h0000FFFE);
    for (int i = 0; i < 3; i++) applyStimulus(12'h777, 12'h777, 1'b1);
    drain(50);
    checkOutput("count_wrap", 32'(o_pix_count), 32'h00000001);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
